// File: rtl/mem_stage_if.sv
// EX/MEM -> MEM/WB bundle for the MIPS memory stage.
// The master drives the i_* pipeline inputs; the slave (mem_stage) drives the o_* results.
interface mem_stage_if #(
    parameter int ADDR_BITS = 8
);
    logic [31:0]          i_alu_result;
    logic [31:0]          i_write_data;
    logic [4:0]           i_write_register;
    logic [5:0]           i_opcode;
    logic                 i_reg_write;
    logic                 i_mem_read;
    logic                 i_mem_write;
    logic                 i_mem_to_reg;
    logic [ADDR_BITS-1:0] i_dbg_addr;

    logic [31:0]          o_read_data;
    logic [31:0]          o_alu_result;
    logic [4:0]           o_write_register;
    logic                 o_reg_write;
    logic                 o_mem_to_reg;
    logic                 o_misaligned;
    logic [31:0]          o_fwd_value;
    logic                 o_fwd_reg_write;
    logic [31:0]          o_dbg_data;

    modport master (
        output i_alu_result, i_write_data, i_write_register, i_opcode,
               i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg, i_dbg_addr,
        input  o_read_data, o_alu_result, o_write_register, o_reg_write,
               o_mem_to_reg, o_misaligned, o_fwd_value, o_fwd_reg_write, o_dbg_data
    );

    modport slave (
        input  i_alu_result, i_write_data, i_write_register, i_opcode,
               i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg, i_dbg_addr,
        output o_read_data, o_alu_result, o_write_register, o_reg_write,
               o_mem_to_reg, o_misaligned, o_fwd_value, o_fwd_reg_write, o_dbg_data
    );
endinterface

// File: rtl/mem_stage.sv
// MIPS MEM stage: byte-enabled data memory, load extraction/extension and the MEM/WB register.
// There is no handshake: every cycle carries one instruction slot (possibly a bubble).
module mem_stage #(
    parameter int ADDR_BITS = 8
) (
    input  logic     clk,
    input  logic     reset,
    mem_stage_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_BITS;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;

    typedef enum logic [1:0] {
        W_BYTE = 2'd0,
        W_HALF = 2'd1,
        W_WORD = 2'd2
    } width_e;

    logic [31:0] mem_q [DEPTH];

    logic [31:0] read_data_q, read_data_d;
    logic [31:0] alu_result_q;
    logic [4:0]  write_register_q;
    logic        reg_write_q, reg_write_d;
    logic        mem_to_reg_q;
    logic        misaligned_q, misaligned_d;
    logic [31:0] dbg_data_q;

    width_e               width;
    logic [ADDR_BITS-1:0] word_idx;
    logic [1:0]           lane;
    logic                 addr_bad;
    logic                 is_load;
    logic                 store_en;
    logic [3:0]           byte_en;
    logic [31:0]          store_data;
    logic [31:0]          rd_word;
    logic [7:0]           rd_byte;
    logic [15:0]          rd_half;
    logic [31:0]          load_ext;
    logic                 unused_addr_hi;

    assign word_idx = bus.i_alu_result[ADDR_BITS+1:2];
    assign lane     = bus.i_alu_result[1:0];
    // Upper address bits are deliberately dropped so addresses wrap modulo the memory depth.
    assign unused_addr_hi = ^bus.i_alu_result[31:ADDR_BITS+2];

    always_comb begin
        case (bus.i_opcode)
            OP_LB, OP_LBU, OP_SB: width = W_BYTE;
            OP_LH, OP_LHU, OP_SH: width = W_HALF;
            default:              width = W_WORD;
        endcase
    end

    always_comb begin
        case (width)
            W_HALF:  addr_bad = lane[0];
            W_WORD:  addr_bad = |lane;
            default: addr_bad = 1'b0;
        endcase
    end

    // A store wins over a simultaneous load, so a slot is only a load when mem_write is clear.
    assign is_load      = bus.i_mem_read & ~bus.i_mem_write;
    assign store_en     = bus.i_mem_write & ~addr_bad & ~reset;
    assign misaligned_d = (bus.i_mem_read | bus.i_mem_write) & addr_bad;

    always_comb begin
        case (width)
            W_BYTE: begin
                byte_en    = 4'b0001 << lane;
                store_data = {4{bus.i_write_data[7:0]}};
            end
            W_HALF: begin
                byte_en    = lane[1] ? 4'b1100 : 4'b0011;
                store_data = {2{bus.i_write_data[15:0]}};
            end
            default: begin
                byte_en    = 4'b1111;
                store_data = bus.i_write_data;
            end
        endcase
    end

    assign rd_word = mem_q[word_idx];
    assign rd_byte = rd_word[{lane, 3'b000} +: 8];
    assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        case (width)
            W_BYTE: begin
                if (bus.i_opcode == OP_LB) load_ext = {{24{rd_byte[7]}}, rd_byte};
                else                       load_ext = {24'd0, rd_byte};
            end
            W_HALF: begin
                if (bus.i_opcode == OP_LH) load_ext = {{16{rd_half[15]}}, rd_half};
                else                       load_ext = {16'd0, rd_half};
            end
            default: load_ext = rd_word;
        endcase
    end

    assign read_data_d = (is_load & ~addr_bad) ? load_ext : 32'd0;
    assign reg_write_d = bus.i_reg_write & ~(is_load & addr_bad);

    always_ff @(posedge clk) begin
        if (store_en) begin
            for (int l = 0; l < 4; l++) begin
                if (byte_en[l]) mem_q[word_idx][8*l +: 8] <= store_data[8*l +: 8];
            end
        end
    end

    // Debug read samples the array before this edge's store lands (read-before-write).
    always_ff @(posedge clk) begin
        if (reset) begin
            read_data_q      <= 32'd0;
            alu_result_q     <= 32'd0;
            write_register_q <= 5'd0;
            reg_write_q      <= 1'b0;
            mem_to_reg_q     <= 1'b0;
            misaligned_q     <= 1'b0;
            dbg_data_q       <= 32'd0;
        end else begin
            read_data_q      <= read_data_d;
            alu_result_q     <= bus.i_alu_result;
            write_register_q <= bus.i_write_register;
            reg_write_q      <= reg_write_d;
            mem_to_reg_q     <= bus.i_mem_to_reg;
            misaligned_q     <= misaligned_d;
            dbg_data_q       <= mem_q[bus.i_dbg_addr];
        end
    end

    assign bus.o_read_data      = read_data_q;
    assign bus.o_alu_result     = alu_result_q;
    assign bus.o_write_register = write_register_q;
    assign bus.o_reg_write      = reg_write_q;
    assign bus.o_mem_to_reg     = mem_to_reg_q;
    assign bus.o_misaligned     = misaligned_q;
    assign bus.o_fwd_value      = mem_to_reg_q ? read_data_q : alu_result_q;
    assign bus.o_fwd_reg_write  = reg_write_q;
    assign bus.o_dbg_data       = dbg_data_q;
endmodule

// File: tb/tb_mem_stage.sv
// Randomised and directed bench for mem_stage against a byte-addressed memory model.
module tb_mem_stage;
  localparam int AB = 8;
  localparam int W  = 139;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_stage_if #(.ADDR_BITS(AB)) bus ();
  mem_stage #(.ADDR_BITS(AB)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [W-1:0] exp_q[$];
  logic [7:0]   mm[1024];
  int           n_vec = 0;
  int           n_bad = 0;
  bit           model_valid = 0;
  int           dbg_force = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_word(input int idx);
    return {mm[idx*4+3], mm[idx*4+2], mm[idx*4+1], mm[idx*4]};
  endfunction

  // One instruction slot: drive inputs, advance the model, queue the MEM/WB image.
  task automatic drive(input logic rst, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] wr, input logic [5:0] op, input logic rw,
                       input logic mr, input logic mw, input logic m2r, input logic skip_in);
    int w;
    int base;
    int d;
    logic mis, is_ld;
    logic [31:0] rd, fwd, dbgv;
    logic rwo;
    logic skip_rd, skip_dbg;
    d = (dbg_force >= 0) ? dbg_force : int'($urandom_range(0, 255));
    reset = rst;
    bus.i_alu_result = alu;
    bus.i_write_data = wd;
    bus.i_write_register = wr;
    bus.i_opcode = op;
    bus.i_reg_write = rw;
    bus.i_mem_read = mr;
    bus.i_mem_write = mw;
    bus.i_mem_to_reg = m2r;
    bus.i_dbg_addr = d[AB-1:0];
    if (op == 6'h20 || op == 6'h24 || op == 6'h28) w = 1;
    else if (op == 6'h21 || op == 6'h25 || op == 6'h29) w = 2;
    else w = 4;
    base = int'(alu[9:0]);
    mis = (mr || mw) && (base % w != 0);
    is_ld = mr && !mw;
    if (rst) begin
      exp_q.push_back({2'b00, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0});
    end else begin
      dbgv = model_word(d);
      rd = 32'd0;
      if (is_ld && !mis) begin
        for (int k = 0; k < w; k++) rd = rd | (32'(mm[base+k]) << (8*k));
        if (op == 6'h20) rd = {{24{rd[7]}}, rd[7:0]};
        if (op == 6'h21) rd = {{16{rd[15]}}, rd[15:0]};
      end
      if (mw && !mis) begin
        for (int k = 0; k < w; k++) mm[base+k] = wd[8*k +: 8];
      end
      rwo = rw && !(is_ld && mis);
      fwd = m2r ? rd : alu;
      skip_rd = skip_in || (is_ld && mis);
      skip_dbg = !model_valid;
      exp_q.push_back({skip_dbg, skip_rd, rd, alu, wr, rwo, m2r, mis, fwd, rwo, dbgv});
    end
    @(negedge clk);
  endtask

  task automatic st(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
    drive(1'b0, a, d, 5'($urandom_range(0, 31)), op, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic ld(input logic [5:0] op, input logic [31:0] a);
    drive(1'b0, a, $urandom, 5'($urandom_range(1, 31)), op, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic bubble();
    drive(1'b0, 32'd0, 32'd0, 5'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Scoreboard monitor: one MEM/WB image per clock once stimulus has started.
  always @(posedge clk) begin
    logic sd, sr, rw, m2r, mis, frw;
    logic [31:0] rd, alu, fwd, dbgv;
    logic [4:0] wr;
    #1;
    if (exp_q.size() > 0) begin
      {sd, sr, rd, alu, wr, rw, m2r, mis, fwd, frw, dbgv} = exp_q.pop_front();
      if (!sr) chk("read_data", bus.o_read_data, rd);
      if (!sr) chk("fwd_value", bus.o_fwd_value, fwd);
      chk("alu_result", bus.o_alu_result, alu);
      chk("write_register", 32'(bus.o_write_register), 32'(wr));
      chk("reg_write", 32'(bus.o_reg_write), 32'(rw));
      chk("mem_to_reg", 32'(bus.o_mem_to_reg), 32'(m2r));
      chk("misaligned", 32'(bus.o_misaligned), 32'(mis));
      chk("fwd_reg_write", 32'(bus.o_fwd_reg_write), 32'(frw));
      if (!sd) chk("dbg_data", bus.o_dbg_data, dbgv);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24;
  localparam logic [5:0] LHU = 6'h25, SB = 6'h28, SH = 6'h29, SW = 6'h2B;

  initial begin
    logic [5:0] ops[8];
    ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW};
    for (int i = 0; i < 1024; i++) mm[i] = 8'h00;
    bus.i_alu_result = 0; bus.i_write_data = 0; bus.i_write_register = 0;
    bus.i_opcode = 0; bus.i_reg_write = 0; bus.i_mem_read = 0; bus.i_mem_write = 0;
    bus.i_mem_to_reg = 0; bus.i_dbg_addr = 0;
    @(negedge clk);

    // Reset with a store pending: outputs zero, store suppressed.
    repeat (2) drive(1'b1, 32'h10, 32'hDEADBEEF, 5'd3, SW, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 32'h10, 32'h0, 5'd4, LW, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("reset_write_suppressed", 32'(bus.o_read_data != 32'hDEADBEEF), 32'd1);

    for (int i = 0; i < 256; i++) st(SW, 32'(i * 4), $urandom);
    model_valid = 1;
    bubble();

    st(SW, 32'h20, 32'h11223344);
    ld(LW, 32'h20);
    chk("lw_after_sw", bus.o_read_data, 32'h11223344);
    chk("lw_after_sw_fwd", bus.o_fwd_value, 32'h11223344);

    st(SW, 32'h30, 32'h0);
    st(SB, 32'h31, 32'hABCDEF80);
    ld(LB, 32'h31);
    chk("lb_sign", bus.o_read_data, 32'hFFFFFF80);
    ld(LBU, 32'h31);
    chk("lbu_zero", bus.o_read_data, 32'h00000080);
    st(SH, 32'h32, 32'h12348001);
    ld(LH, 32'h32);
    chk("lh_sign", bus.o_read_data, 32'hFFFF8001);
    ld(LHU, 32'h32);
    chk("lhu_zero", bus.o_read_data, 32'h00008001);
    ld(LW, 32'h30);
    chk("lw_lanes", bus.o_read_data, 32'h80018000);

    st(SW, 32'h40, 32'h12345678);
    st(SW, 32'h41, 32'hFFFFFFFF);
    chk("sw_misaligned_flag", 32'(bus.o_misaligned), 32'd1);
    ld(LH, 32'h43);
    chk("lh_misaligned_regw", 32'(bus.o_reg_write), 32'd0);
    chk("lh_misaligned_flag", 32'(bus.o_misaligned), 32'd1);
    ld(LW, 32'h40);
    chk("misaligned_no_write", bus.o_read_data, 32'h12345678);

    st(SW, 32'h400, 32'hCAFEF00D);
    ld(LW, 32'h000);
    chk("addr_wrap", bus.o_read_data, 32'hCAFEF00D);

    st(SW, 32'h14, 32'h0);
    dbg_force = 5;
    st(SW, 32'h14, 32'h5);
    chk("dbg_read_before_write", bus.o_dbg_data, 32'h0);
    bubble();
    chk("dbg_new_data", bus.o_dbg_data, 32'h5);
    dbg_force = -1;

    for (int i = 0; i < 600; i++) begin
      int kind;
      logic [31:0] a;
      logic [5:0] op;
      logic mr, mw;
      kind = $urandom_range(0, 9);
      a = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
      mr = (kind >= 1 && kind <= 4) || kind == 9;
      mw = (kind >= 5 && kind <= 8) || kind == 9;
      if (kind == 0) bubble();
      else drive(1'b0, a, $urandom, 5'($urandom), op, 1'($urandom), mr, mw, 1'($urandom), 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MIPS pipeline MEM stage. Consumes the EX/MEM results: ALU result (address or data), store data (rt), destination register, reg_write, mem_read, mem_write, mem_to_reg, plus opcode for access width.
- Owns the data memory: byte-enabled synchronous writes, synchronous reads with sign/zero extension.
- Drives the registered MEM/WB outputs.
- Exports the forwarding source value and control that feed EX forwarding for operands A/B.

Parameters:
- ADDR_BITS, 8, log2 of data-memory depth in 32-bit words (256 words = 1 KiB).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- i_alu_result  in  32  byte address for loads/stores; pass-through value otherwise
- i_write_data  in  32  forwarded rt value for stores
- i_write_register  in  5  destination register
- i_opcode  in  6  selects access width/signedness
- i_reg_write  in  1  register write enable
- i_mem_read  in  1  load
- i_mem_write  in  1  store
- i_mem_to_reg  in  1  WB selects memory data (1) or ALU result (0)
- i_dbg_addr  in  ADDR_BITS  debug word-read index
- o_read_data  out  32  extended load data (MEM/WB)
- o_alu_result  out  32  registered ALU result (MEM/WB)
- o_write_register  out  5  registered destination
- o_reg_write  out  1  registered reg_write, gated by misalignment
- o_mem_to_reg  out  1  registered mem_to_reg
- o_misaligned  out  1  one-cycle flag for the access just latched
- o_fwd_value  out  32  WB value from MEM/WB: o_mem_to_reg ? o_read_data : o_alu_result (combinational)
- o_fwd_reg_write  out  1  equals o_reg_write
- o_dbg_data  out  32  registered debug word

Behaviour:
- Reset:
  - All registered outputs are 0 on the first edge with reset=1.
  - Memory contents are not cleared.
  - Writes are suppressed while reset=1.
- Addressing:
  - Word index = i_alu_result[ADDR_BITS+1:2]; upper bits are ignored (address wraps modulo depth).
  - Byte lane = i_alu_result[1:0]. Little-endian: lane 0 = bits 7:0.
- Opcodes: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B.
  - Any other opcode with mem_read or mem_write set is treated as word access.
- Misalignment:
  - Halfword access with addr[0]=1, or word access with addr[1:0]!=0, is misaligned.
  - A misaligned store performs no write.
  - A misaligned load forces o_reg_write=0.
  - Either case sets o_misaligned=1 for that one cycle.
- Store (i_mem_write=1, aligned):
  - Write occurs on the same rising edge.
  - SB: byte enable on lane addr[1:0], data i_write_data[7:0] replicated.
  - SH: lanes {1,0} or {3,2}, data i_write_data[15:0].
  - SW: all lanes.
- Load (i_mem_read=1):
  - Word is read on the edge; extracted and extended (sign for LB/LH, zero for LBU/LHU) into o_read_data on that same edge.
  - Total latency 1 cycle: the value appears in the MEM/WB register alongside o_write_register.
- Non-load cycles: o_read_data = 0.
- i_mem_read and i_mem_write both set: the store takes priority and o_read_data = 0.
- Store followed by load to the same word on the next cycle: the load returns the newly written data.
- Debug read: o_dbg_data = mem[i_dbg_addr] registered. If the same word is stored in the same cycle, the old data is returned (read-before-write).
- Pass-through: o_alu_result, o_write_register and o_mem_to_reg register their inputs every cycle; there is no stall or enable.
- Bubble (all controls 0): outputs carry 0 controls, and memory is untouched.

Test Plan:
- Reset with i_mem_write=1, i_alu_result=0x10, data=0xDEADBEEF; then LW 0x10 after reset -> all outputs 0 during reset; the stored word is not 0xDEADBEEF (write suppressed).
- SW 0x11223344 @0x20; next cycle LW @0x20 -> o_read_data=0x11223344, o_mem_to_reg=1, o_fwd_value=0x11223344.
- Extension:
  - SB 0x80 @0x31; LB @0x31 -> 0xFFFFFF80.
  - LBU @0x31 -> 0x00000080.
  - SH 0x8001 @0x32; LH @0x32 -> 0xFFFF8001; LHU -> 0x00008001.
  - LW @0x30 -> 0x80018000 (lane 0 untouched = 0x00).
- Misalignment:
  - SW @0x41 -> no write, o_misaligned=1.
  - LH @0x43 with reg_write=1 -> o_reg_write=0, o_misaligned=1.
  - LW @0x40 -> prior contents.
- Wrap: SW 0xCAFEF00D @0x400 (ADDR_BITS=8); LW @0x000 -> 0xCAFEF00D.
- Debug same-cycle: i_dbg_addr=5 while SW 0x5 @0x14 over old 0x0 -> o_dbg_data=0x0; next cycle o_dbg_data=0x5.
